// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding and BCD limits for the digital clock blocks
package clock_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
endpackage

// File: rtl/bcd_time_add.sv
// bcd_time_add: adds 0..9 minutes to a packed-BCD hh:mm, wrapping 59->00 and 23->00
//   hour, minute : packed BCD input time
//   add          : minutes to add (0..9)
//   sum_hour     : wrapped BCD hour
//   sum_minute   : wrapped BCD minute
module bcd_time_add
  import clock_pkg::*;
(
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [3:0] add,
  output logic [7:0] sum_hour,
  output logic [7:0] sum_minute
);
  logic [4:0] ones;
  logic [3:0] tens;
  logic       oc, hc;
  logic [7:0] hinc;
  assign ones = {1'b0, minute[3:0]} + {1'b0, add};
  assign oc = ones > 5'd9;
  assign tens = minute[7:4] + {3'd0, oc};
  // add is at most 9, so at most one tens carry and the minute total never exceeds 68
  assign hc = {tens, 4'd0} > BCD_59;
  assign sum_minute = {hc ? 4'd0 : tens, 4'(oc ? ones - 5'd10 : ones)};
  assign hinc = (hour == BCD_23) ? 8'h00 :
                (hour[3:0] == 4'd9) ? {hour[7:4] + 4'd1, 4'd0} : hour + 8'd1;
  assign sum_hour = hc ? hinc : hour;
endmodule

// File: rtl/alarm_beeper.sv
// alarm_beeper: alarm match, ring with gated piezo tone, snooze, stop and auto-off
//   clk, rst                       : system clock, async active-low reset
//   clk1sec                        : one-cycle 1 Hz enable
//   hour, minute, second           : current time, packed BCD
//   alarm_hour, alarm_minute       : alarm setting, packed BCD
//   alarm_en                       : alarm armed
//   sw_stop, sw_snooze             : debounced switch levels
//   piezo, ringing, snoozed        : registered outputs
module alarm_beeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TONE_HZ    = 2000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1sec,
  input  logic [7:0] hour,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_minute,
  input  logic       alarm_en,
  input  logic       sw_stop,
  input  logic       sw_snooze,
  output logic       piezo,
  output logic       ringing,
  output logic       snoozed
);
  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int GATE = CLK_HZ / 2;
  localparam int TW = $clog2(HALF + 1);
  localparam int GW = $clog2(GATE + 1);
  state_t          state, nxt;
  logic            stop_d, snz_d, stop_p, snz_p;
  logic [7:0]      rcnt, tgt_h, tgt_m, sum_h, sum_m;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            tone, tone_n, gate, gate_n;
  logic            tick, alarm_hit, snz_hit, timeout, hold, t_wrap, g_wrap;
  bcd_time_add u_add (
    .hour      (hour),
    .minute    (minute),
    .add       (4'(SNOOZE_MIN)),
    .sum_hour  (sum_h),
    .sum_minute(sum_m)
  );
  assign tick = clk1sec & alarm_en & (second == 8'h00);
  assign alarm_hit = tick & (hour == alarm_hour) & (minute == alarm_minute);
  assign snz_hit = tick & (hour == tgt_h) & (minute == tgt_m);
  assign timeout = clk1sec & (rcnt == 8'(RING_SEC - 1));
  // stop outranks snooze and timeout; snooze outranks timeout
  always_comb begin
    nxt = (state == IDLE) ? (alarm_hit ? RING : IDLE) :
          (!alarm_en || stop_p) ? IDLE :
          (state == RING) ? (snz_p ? SNOOZE : timeout ? IDLE : RING) :
          (snz_hit ? RING : SNOOZE);
  end
  // counters only run while staying in RING, so every RING entry starts cleared with gate on
  assign hold = (state == RING) && (nxt == RING);
  assign t_wrap = tcnt == TW'(HALF - 1);
  assign g_wrap = gcnt == GW'(GATE - 1);
  assign tcnt_n = (hold && !t_wrap) ? tcnt + TW'(1) : '0;
  assign gcnt_n = (hold && !g_wrap) ? gcnt + GW'(1) : '0;
  assign tone_n = hold & (tone ^ t_wrap);
  assign gate_n = !hold | (gate ^ g_wrap);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      stop_d  <= 1'b0;
      snz_d   <= 1'b0;
      stop_p  <= 1'b0;
      snz_p   <= 1'b0;
      rcnt    <= 8'd0;
      tcnt    <= '0;
      gcnt    <= '0;
      tone    <= 1'b0;
      gate    <= 1'b1;
      tgt_h   <= 8'h00;
      tgt_m   <= 8'h00;
      piezo   <= 1'b0;
      ringing <= 1'b0;
      snoozed <= 1'b0;
    end else begin
      state   <= nxt;
      stop_d  <= sw_stop;
      snz_d   <= sw_snooze;
      stop_p  <= sw_stop & ~stop_d;
      snz_p   <= sw_snooze & ~snz_d;
      rcnt    <= hold ? rcnt + {7'd0, clk1sec} : 8'd0;
      tcnt    <= tcnt_n;
      gcnt    <= gcnt_n;
      tone    <= tone_n;
      gate    <= gate_n;
      if (state == RING && nxt == SNOOZE) begin
        tgt_h <= sum_h;
        tgt_m <= sum_m;
      end
      piezo   <= tone_n & gate_n;
      ringing <= nxt == RING;
      snoozed <= nxt == SNOOZE;
    end
  end
endmodule

// File: tb/tb_alarm_beeper.sv
// tb_alarm_beeper: directed and randomized checks of alarm_beeper against a time-based model
module tb_alarm_beeper;
  localparam int CLK_HZ = 1000, TONE_HZ = 100, RING_SEC = 60, SNOOZE_MIN = 5;
  localparam int HALF = CLK_HZ / (2 * TONE_HZ), GATE = CLK_HZ / 2;
  logic clk = 0, rst = 0, clk1sec = 0, alarm_en = 0, sw_stop = 0, sw_snooze = 0;
  logic [7:0] hour = 0, minute = 0, second = 0, alarm_hour = 0, alarm_minute = 0;
  logic piezo, ringing, snoozed;
  int checks = 0, failures = 0;
  int th = 0, tm = 0, ts = 0, ah = 0, am = 0;
  bit m_ring, m_snz, p_stop, p_snz, q_stop, q_snz;
  int m_secs, m_t, m_tgt;
  alarm_beeper #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec), .hour(hour), .minute(minute), .second(second),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_en(alarm_en),
    .sw_stop(sw_stop), .sw_snooze(sw_snooze), .piezo(piezo), .ringing(ringing), .snoozed(snoozed)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0b exp=%0b (time %0d:%0d:%0d)", tag, got, exp, th, tm, ts);
    end
  endtask
  task automatic drive();
    hour = bcd(th); minute = bcd(tm); second = bcd(ts);
    alarm_hour = bcd(ah); alarm_minute = bcd(am);
  endtask
  task automatic set_time(input int h, input int m, input int s);
    th = h; tm = m; ts = s; drive();
  endtask
  task automatic set_alarm(input int h, input int m);
    ah = h; am = m; drive();
  endtask
  task automatic tick_time();
    int tot;
    tot = (th * 3600 + tm * 60 + ts + 1) % 86400;
    set_time(tot / 3600, (tot / 60) % 60, tot % 60);
  endtask
  task automatic model_clear();
    m_ring = 0; m_snz = 0; p_stop = 0; p_snz = 0; q_stop = 0; q_snz = 0;
    m_secs = 0; m_t = 0; m_tgt = 0;
  endtask
  // one clock edge of the reference behaviour, using the inputs the DUT is about to sample
  task automatic model_step();
    bit sa, na, tk;
    int now;
    sa = p_stop; na = p_snz; now = th * 60 + tm;
    tk = clk1sec && alarm_en && ts == 0;
    p_stop = sw_stop && !q_stop; q_stop = sw_stop;
    p_snz = sw_snooze && !q_snz; q_snz = sw_snooze;
    if (!m_ring && !m_snz) begin
      if (tk && now == ah * 60 + am) begin m_ring = 1; m_secs = 0; m_t = 0; end
    end else if (!alarm_en || sa) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring) begin
      if (clk1sec) m_secs++;
      if (na) begin m_ring = 0; m_snz = 1; m_tgt = (now + SNOOZE_MIN) % 1440; end
      else if (m_secs == RING_SEC) m_ring = 0;
      else m_t++;
    end else if (tk && now == m_tgt) begin
      m_snz = 0; m_ring = 1; m_secs = 0; m_t = 0;
    end
  endtask
  function automatic bit exp_piezo();
    return m_ring && ((m_t / HALF) % 2 == 1) && ((m_t / GATE) % 2 == 0);
  endfunction
  task automatic cyc(input bit pulse);
    clk1sec = pulse;
    drive();
    model_step();
    @(posedge clk); #1;
    check("ringing", ringing, m_ring);
    check("snoozed", snoozed, m_snz);
    check("piezo", piezo, exp_piezo());
    clk1sec = 0;
    if (pulse) tick_time();
  endtask
  task automatic run(input int n, input int per);
    for (int i = 0; i < n; i++) cyc(per > 0 && (i % per == per - 1));
  endtask
  task automatic do_reset();
    rst = 0; sw_stop = 0; sw_snooze = 0;
    #1;
    check("rst_piezo", piezo, 1'b0);
    check("rst_ringing", ringing, 1'b0);
    check("rst_snoozed", snoozed, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask
  task automatic ring_at(input int h, input int m);
    set_alarm(h, m);
    set_time((h * 60 + m + 1439) / 60 % 24, (m + 59) % 60, 59);
    cyc(1);
    check("pre_ring", ringing, 1'b0);
    cyc(1);
    check("ring_rise", ringing, 1'b1);
  endtask
  initial begin
    model_clear();
    @(posedge clk); #1;
    do_reset();
    alarm_en = 1;
    // ring at 07:30 and observe tone through gate-on, gate-off and gate-on again
    ring_at(7, 30);
    run(1100 + $urandom_range(0, 40), 0);
    sw_stop = 1;
    cyc(0);
    check("stop_n1", ringing, 1'b1);
    cyc(0);
    check("stop_n2", ringing, 1'b0);
    check("stop_piezo", piezo, 1'b0);
    run($urandom_range(0, 3), 0);
    sw_stop = 0;
    set_time(7, 30, 50);
    run(150, 2);
    check("no_rering", ringing, 1'b0);
    // snooze across midnight: 23:58 + 5 -> 00:03
    ring_at(23, 58);
    run(40, 2);
    sw_snooze = 1;
    cyc(0);
    cyc(0);
    check("snz_on", snoozed, 1'b1);
    check("snz_ring_off", ringing, 1'b0);
    sw_snooze = 0;
    run(10, 2);
    set_time(0, 2, 58);
    cyc(1);
    cyc(1);
    check("snz_early", ringing, 1'b0);
    cyc(1);
    check("snz_resume", ringing, 1'b1);
    check("snz_off", snoozed, 1'b0);
    sw_stop = 1; cyc(0); cyc(0); sw_stop = 0; cyc(0);
    // auto-off after RING_SEC pulses in RING
    ring_at(0, 10);
    run((RING_SEC - 1) * 3, 3);
    check("to_before", ringing, 1'b1);
    cyc(1);
    check("to_after", ringing, 1'b0);
    // stop and snooze in the same cycle
    ring_at(0, 20);
    sw_stop = 1; sw_snooze = 1;
    cyc(0); cyc(0);
    check("both_ring", ringing, 1'b0);
    check("both_snz", snoozed, 1'b0);
    run(20, 0);
    sw_stop = 0; sw_snooze = 0;
    run(5, 0);
    check("both_snz_late", snoozed, 1'b0);
    // alarm_en dropped while snoozed
    ring_at(0, 30);
    sw_snooze = 1; cyc(0); cyc(0); sw_snooze = 0;
    check("en_snz", snoozed, 1'b1);
    alarm_en = 0;
    cyc(0);
    check("en_drop", snoozed, 1'b0);
    run(3, 0);
    alarm_en = 1;
    set_time(0, 34, 59);
    cyc(1); cyc(1);
    check("en_no_ring", ringing, 1'b0);
    // reset while the tone is high
    ring_at(0, 40);
    run(HALF + 1, 0);
    check("rst_pre_piezo", piezo, 1'b1);
    do_reset();
    // reset while snoozed forgets the target
    ring_at(0, 50);
    sw_snooze = 1; cyc(0); cyc(0); sw_snooze = 0;
    check("rst_snz", snoozed, 1'b1);
    do_reset();
    set_time(0, 54, 59);
    cyc(1); cyc(1);
    check("rst_no_ring", ringing, 1'b0);
    // randomized activity around random alarm times
    for (int b = 0; b < 12; b++) begin
      int tot;
      set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
      tot = (ah * 3600 + am * 60 - $urandom_range(1, 8) + 86400) % 86400;
      set_time(tot / 3600, (tot / 60) % 60, tot % 60);
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 39) == 0) sw_stop = ~sw_stop;
        if ($urandom_range(0, 29) == 0) sw_snooze = ~sw_snooze;
        alarm_en = $urandom_range(0, 149) != 0;
        if (m_snz && $urandom_range(0, 24) == 0) begin
          tot = (m_tgt * 60 - 1 + 86400) % 86400;
          set_time(tot / 3600, (tot / 60) % 60, tot % 60);
        end
        cyc($urandom_range(0, 2) == 0);
      end
      sw_stop = 1; cyc(0); cyc(0); sw_stop = 0; sw_snooze = 0; cyc(0);
      alarm_en = 1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_beeper.md
# alarm_beeper

Alarm match, ring and snooze controller that consumes the BCD time from `watch_time` and the alarm setting held by the alarm mode. It compares time against the alarm once per second, drives a gated square-wave tone onto a piezo pin, and implements stop, snooze and auto-off. It sits beside `mode_watch` and `mode_alarm` in `digital_clock`, fed by the debounced switches and the 1 Hz enable.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TONE_HZ`, default 2000: piezo tone frequency.
- `RING_SEC`, default 60: auto-off timeout in seconds. Range 1..255.
- `SNOOZE_MIN`, default 5: snooze length in minutes. Range 1..9.

Ports:
- `clk` input 1: system clock; one clock domain.
- `rst` input 1: reset, asynchronous and active-low.
- `clk1sec` input 1: one-cycle 1 Hz enable pulse.
- `hour`, `minute`, `second` input 8 each: current time, packed BCD.
- `alarm_hour`, `alarm_minute` input 8 each: alarm setting, packed BCD.
- `alarm_en` input 1: alarm armed (level).
- `sw_stop`, `sw_snooze` input 1 each: debounced switch levels, active-high.
- `piezo` output 1: tone output.
- `ringing` output 1: high in RING state.
- `snoozed` output 1: high in SNOOZE state.

## Operation

- States: IDLE, RING, SNOOZE. Reset puts the block in IDLE with `piezo`, `ringing` and `snoozed` at 0 and all counters cleared.
- Switch inputs are rising-edge detected internally through one register stage each. A held switch acts once.
- Alarm match: `clk1sec` & `alarm_en` & `second`==8'h00 & `hour`==`alarm_hour` & `minute`==`alarm_minute`.
- IDLE -> RING on alarm match.
- RING:
  - The ring counter increments on each `clk1sec`.
  - When the counter reaches `RING_SEC`, go to IDLE.
  - Stop edge -> IDLE.
  - Snooze edge -> SNOOZE, latching the snooze target = current `hour:minute` + `SNOOZE_MIN` in BCD. Minutes wrap 59->00 with an hour carry; hours wrap 23->00.
  - `alarm_en` low -> IDLE.
- SNOOZE:
  - Snooze match (same as alarm match, but against the latched target) -> RING, with the ring counter reset.
  - Stop edge -> IDLE. `alarm_en` low -> IDLE.
  - Snooze edges are ignored.
- Simultaneous events: stop beats snooze, and stop beats timeout. An alarm match is ignored while in RING or SNOOZE. It is evaluated only in IDLE, so a re-match in the same minute cannot occur because `second` must equal 00.
- Tone: the half-period counter reloads at `CLK_HZ/(2*TONE_HZ)`-1 and toggles a tone flop.
- Beep gate: toggles every `CLK_HZ/2` cycles, giving 0.5 s on / 0.5 s off. It is forced on at RING entry.
- `piezo` = tone & gate in RING, otherwise 0. The tone and gate counters are held cleared outside RING.

## Timing

- All outputs are registered.
- `ringing` rises exactly 1 cycle after the `clk1sec` cycle that produces the match.
- `piezo` first rises `CLK_HZ/(2*TONE_HZ)` cycles after RING entry.
- A stop or snooze edge presented at cycle N clears `ringing` at N+2: one cycle for edge detect, one for the state register.
- The timeout exits to IDLE on the cycle after the `RING_SEC`-th `clk1sec` pulse in RING.
- Reset mid-ring: `piezo` drops asynchronously. The snooze target is not retained.
- Inputs `hour`, `minute` and `second` are sampled only in `clk1sec` cycles. `watch_time` updates them on the same pulse, so the comparison uses the pre-update value. An alarm of 07:30 therefore fires when the time shows 07:30:00, one second after the display reads 07:30:00.

## Structure

- The shared package `clock_pkg` holds:
  - the state enum (IDLE=2'd0, RING=2'd1, SNOOZE=2'd2);
  - the BCD constants `BCD_59`=8'h59 and `BCD_23`=8'h23.
- One sub-module, `bcd_time_add`: combinational. Inputs are 8-bit BCD hour and minute plus a 4-bit addend (0..9). Outputs are the wrapped BCD hour and minute. It is reused later for the time-set mode.
- Tone and gate dividers are local counters, with widths from `$clog2`.

## Test plan

- Parameters `CLK_HZ`=1000, `TONE_HZ`=100 for all scenarios.
- Alarm 07:30, `alarm_en`=1, time advanced to 07:30:00 -> `ringing`=1 one cycle after the pulse; `piezo` toggles every 5 cycles during gate-on, 0 during gate-off.
- Ringing, then `sw_stop` pulse -> `ringing`=0 two cycles later, `piezo`=0; no re-ring through 07:31:00.
- Alarm 23:58, snooze pressed at 23:58:20 with `SNOOZE_MIN`=5 -> `snoozed`=1, target 00:03; ring resumes at 00:03:00.
- No input for 60 pulses after ring start -> IDLE after the 60th pulse; `ringing`=0.
- `sw_stop` and `sw_snooze` rising in the same cycle -> IDLE, `snoozed` stays 0.
- `alarm_en` dropped during SNOOZE, or `rst` asserted while ringing -> outputs 0 (immediately for `rst`); no ring at the snooze target.
